uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//   Receive front end for one UART channel. Synchronises the raw uart_rx pin, detects start
//   bits, samples 8N1 frames at mid-bit and emits one-cycle byte strobes into the channel's
//   RX buffer. Sits between the pad and the per-channel RX FIFO of each UART device.
// PARAMETERS
//   CLOCK_SCALE_BITS  16  width of cyclesPerBit; bit period in clk cycles
// PORTS
//   clk           in   1                 system clock
//   rst           in   1                 asynchronous, active-high reset
//   enable        in   1                 receiver enable; low forces IDLE
//   cyclesPerBit  in   CLOCK_SCALE_BITS  clk cycles per bit (values <4 treated as 4)
//   parityEnable  in   1                 parity bit present (used only with UART_RX_PARITY_EN)
//   parityOdd     in   1                 1=odd, 0=even parity (used only with UART_RX_PARITY_EN)
//   uart_rx       in   1                 raw serial input, idle high
//   dataOut       out  8                 last received byte, held until next valid byte
//   dataValid     out  1                 one-cycle strobe: dataOut updated with a good frame
//   frameError    out  1                 one-cycle strobe: stop bit sampled low
//   parityError   out  1                 one-cycle strobe: parity mismatch (0 without macro)
//   busy          out  1                 high in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, synchroniser flops=1, dataOut=8'h00, all strobes=0, busy=0.
//   - uart_rx passes through 2 flops (reset to 1); all sampling uses the synchronised value.
//   - cyclesPerBit is latched on leaving IDLE. Mid-frame changes apply from the next frame.
//   - Counter reloads with latched period P. A sample is taken when the counter reaches 0.
//   - States:
//     IDLE: synced rx 1->0 edge and enable -> START, counter=(P>>1)-1.
//     START: mid-bit sample. rx=0 -> DATA, counter=P-1, bitIndex=0. rx=1 -> IDLE (glitch).
//     DATA: sample every P cycles, LSB first into shift reg. After bit 7 -> PARITY if
//       parity is active, else -> STOP. Counter=P-1 on each transition.
//     PARITY (macro only): sample the parity bit and compare with the XOR of the data,
//       inverted when parityOdd -> STOP.
//     STOP: sample. rx=1 -> dataOut<=shift reg, dataValid=1 for exactly 1 cycle -> IDLE.
//       rx=0 -> frameError=1 for 1 cycle, dataOut unchanged, dataValid stays 0 -> BREAK.
//     BREAK: wait for synced rx=1 -> IDLE. No start detection while in BREAK.
//   - Parity failure with a good stop bit: dataValid and parityError both pulse in the
//     same cycle, and dataOut updates. Parity failure with a bad stop bit: frameError and
//     parityError pulse together.
//   - A falling edge during the same cycle as the IDLE return from STOP is not lost.
//     Edge detection uses the registered previous synced value.
//   - enable=0 in any state: -> IDLE next cycle, partial frame discarded, no strobes.
//   - Strobes are registered outputs, never asserted simultaneously with reset.
//   - Latency: dataValid rises 1 cycle after the stop-bit mid-sample.
//     That is about 9.5*P + 3 cycles after the pin falling edge.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     parityEnable and parityOdd are honoured. PARITY state and parityError are active.
//   Undefined:
//     parity inputs are ignored and the PARITY state is not synthesised.
//     parityError is tied 0. Frame is always 8N1.
// TESTING
//   - Reset with uart_rx=1: all outputs 0, busy=0, dataOut=8'h00.
//   - P=16, send 8'hA5 8N1: one dataValid pulse, dataOut=8'hA5, frameError=0.
//     Back-to-back 8'h00 then 8'hFF with no idle gap: two pulses, correct bytes.
//   - P=16, 3-cycle low glitch on uart_rx: returns to IDLE from START, no strobes.
//   - P=16, 8'h3C with stop bit low and line low 40 cycles: frameError 1 cycle.
//     dataValid=0, busy until line high, then next frame 8'h81 received correctly.
//   - enable dropped at data bit 4 of 8'h55: busy=0 in 2 cycles, no strobes.
//     Re-enable and send 8'h55: received correctly.
//   - With UART_RX_PARITY_EN, even parity, send 8'h07 with parity bit 0: dataValid and
//     parityError pulse together. With parity bit 1: dataValid only.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - UART receive deserializer, 8N1 with optional parity (UART_RX_PARITY_EN)
// Synchronises the pin, finds start bits, samples at mid-bit and strobes each received byte.
module uart_rx_deserializer #(
   parameter int CLOCK_SCALE_BITS = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
   input  logic                        parityEnable,
   input  logic                        parityOdd,
   input  logic                        uart_rx,
   output logic [7:0]                  dataOut,
   output logic                        dataValid,
   output logic                        frameError,
   output logic                        parityError,
   output logic                        busy
);
   localparam logic [CLOCK_SCALE_BITS-1:0] ONE   = 1;
   localparam logic [CLOCK_SCALE_BITS-1:0] MIN_P = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } state_t;

   state_t                      state_q, state_d;
   logic [CLOCK_SCALE_BITS-1:0] cnt_q, cnt_d, period_q, period_d, p_eff;
   logic [2:0]                  bit_q, bit_d;
   logic [7:0]                  shift_q, shift_d, dout_q, dout_d;
   logic                        valid_q, valid_d, ferr_q, ferr_d;
   logic                        rx_meta_q, rx_sync_q, rx_prev_q;
   logic                        fall, tick, parity_active;

`ifdef UART_RX_PARITY_EN
   logic pbad_q, pbad_d, perr_q, perr_d;
   assign parity_active = parityEnable;
`else
   logic unused_parity;
   assign unused_parity = parityEnable ^ parityOdd;
   assign parity_active = 1'b0;
`endif

   assign p_eff = (cyclesPerBit < MIN_P) ? MIN_P : cyclesPerBit;
   // Previous synced value lets a start edge right after the stop sample still be seen in IDLE.
   assign fall  = rx_prev_q & ~rx_sync_q;
   assign tick  = (cnt_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         period_q  <= MIN_P;
         bit_q     <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbad_q    <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         pbad_q    <= pbad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_d   = pbad_q;
      perr_d   = 1'b0;
`endif
      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (fall) begin
                  period_d = p_eff;
                  cnt_d    = (p_eff >> 1) - ONE;
                  state_d  = S_START;
`ifdef UART_RX_PARITY_EN
                  pbad_d   = 1'b0;
`endif
               end
            end
            S_START: begin
               if (!tick) begin
                  cnt_d = cnt_q - ONE;
               end else if (!rx_sync_q) begin
                  cnt_d   = period_q - ONE;
                  bit_d   = 3'd0;
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_DATA: begin
               if (!tick) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  shift_d = {rx_sync_q, shift_q[7:1]};
                  cnt_d   = period_q - ONE;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = parity_active ? S_PARITY : S_STOP;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (!tick) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  pbad_d  = rx_sync_q != ((^shift_q) ^ parityOdd);
                  cnt_d   = period_q - ONE;
                  state_d = S_STOP;
               end
            end
`endif
            S_STOP: begin
               if (!tick) begin
                  cnt_d = cnt_q - ONE;
               end else begin
`ifdef UART_RX_PARITY_EN
                  perr_d = pbad_q;
`endif
                  if (rx_sync_q) begin
                     dout_d  = shift_q;
                     valid_d = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign dataOut    = dout_q;
   assign dataValid  = valid_q;
   assign frameError = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parityError = perr_q;
`else
   assign parityError = 1'b0;
`endif
   assign busy = (state_q != S_IDLE);

endmodule
